// File: rtl/mem_stage_wbuf.sv
// MEM pipeline stage: scratchpad port, posted-write buffer and a single-master bus FSM.
// Bus loads are ordered behind all buffered stores; the MEM/WB register holds while busy.
module mem_stage_wbuf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter logic [2:0]  SPM_SEL    = 3'b011
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  output logic                busy,
  input  logic                ex_en,
  input  logic [1:0]          ex_mem_op,
  input  logic [ADDR_W+1:0]   ex_out,
  input  logic [DATA_W-1:0]   ex_mem_wr_data,
  output logic [ADDR_W-1:0]   spm_addr,
  output logic                spm_as_,
  output logic                spm_rw,
  output logic [DATA_W-1:0]   spm_wr_data,
  input  logic [DATA_W-1:0]   spm_rd_data,
  output logic                bus_req_,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wr_data,
  input  logic                bus_grnt_,
  input  logic                bus_rdy_,
  input  logic [DATA_W-1:0]   bus_rd_data,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                mem_en,
  output logic                mem_miss_align,
  output logic [DATA_W-1:0]   mem_out,
  output logic                wbuf_empty
);

  localparam int unsigned BA_W  = ADDR_W + 2;
  localparam int unsigned IDX_W = $clog2(WBUF_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACCESS, S_WAIT} state_t;

  state_t state, state_n;

  logic is_ld, is_st, access, mis, is_spm, aligned_acc;
  logic spm_acc, bus_st, bus_ld;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
  logic fifo_empty, full, push, pop;
  logic [ADDR_W-1:0] fa [WBUF_DEPTH];
  logic [DATA_W-1:0] fd [WBUF_DEPTH];
  logic start_wr, start_rd;
  logic rd_live, rd_valid, ld_done, pend_ld;
  logic [DATA_W-1:0] rd_buf;

  // Operation decode; flushed accesses have no side effects
  assign is_ld       = ex_en && (ex_mem_op == 2'b01);
  assign is_st       = ex_en && (ex_mem_op == 2'b10);
  assign access      = is_ld || is_st;
  assign mis         = access && (ex_out[1:0] != 2'b00);
  assign is_spm      = (ex_out[BA_W-1 -: 3] == SPM_SEL);
  assign aligned_acc = access && !mis && !flush;
  assign spm_acc     = aligned_acc && is_spm;
  assign bus_st      = aligned_acc && !is_spm && is_st;
  assign bus_ld      = aligned_acc && !is_spm && is_ld;

  assign spm_as_     = !spm_acc;
  assign spm_rw      = is_st;
  assign spm_addr    = ex_out[BA_W-1:2];
  assign spm_wr_data = ex_mem_wr_data;

  // Posted-write FIFO; a store is pushed once, when the stage actually retires it
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);
  assign full       = (count == PTR_W'(WBUF_DEPTH));
  assign push       = bus_st && !full && !stall;
  assign pop        = (state == S_WAIT) && !bus_rdy_ && bus_rw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa[wr_ptr[IDX_W-1:0]] <= ex_out[BA_W-1:2];
      fd[wr_ptr[IDX_W-1:0]] <= ex_mem_wr_data;
    end
  end

  assign ld_done = (state == S_WAIT) && !bus_rdy_ && !bus_rw && rd_live;
  assign pend_ld = bus_ld && !rd_valid && !rd_live && fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Bus master next-state; buffered writes win over the pending read
  always_comb begin
    state_n  = state;
    start_wr = 1'b0;
    start_rd = 1'b0;
    bus_req_ = 1'b1;
    bus_as_  = 1'b1;
    case (state)
      S_IDLE: if (!fifo_empty || pend_ld) state_n = S_REQ;
      S_REQ: begin
        bus_req_ = 1'b0;
        if (fifo_empty && !pend_ld) begin
          state_n = S_IDLE;
        end else if (!bus_grnt_) begin
          state_n = S_ACCESS;
          if (!fifo_empty) start_wr = 1'b1;
          else             start_rd = 1'b1;
        end
      end
      S_ACCESS: begin
        bus_req_ = 1'b0;
        bus_as_  = 1'b0;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        bus_req_ = 1'b0;
        if (!bus_rdy_) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_rw      <= 1'b0;
    end else if (start_wr) begin
      bus_addr    <= fa[rd_ptr[IDX_W-1:0]];
      bus_wr_data <= fd[rd_ptr[IDX_W-1:0]];
      bus_rw      <= 1'b1;
    end else if (start_rd) begin
      bus_addr    <= ex_out[BA_W-1:2];
      bus_wr_data <= '0;
      bus_rw      <= 1'b0;
    end
  end

  // Read tracking: flush orphans an in-flight read; data is kept if it lands under stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_live  <= 1'b0;
      rd_valid <= 1'b0;
      rd_buf   <= '0;
    end else begin
      if (start_rd)                                    rd_live <= 1'b1;
      else if (flush || ((state == S_WAIT) && !bus_rdy_)) rd_live <= 1'b0;
      if (flush)        rd_valid <= 1'b0;
      else if (ld_done) rd_valid <= stall;
      else if (!stall)  rd_valid <= 1'b0;
      if (ld_done) rd_buf <= bus_rd_data;
    end
  end

  assign busy       = (bus_st && full) || (bus_ld && !rd_valid && !ld_done);
  assign wbuf_empty = fifo_empty &&
                      !(((state == S_ACCESS) || (state == S_WAIT)) && bus_rw);

  always_comb begin
    fwd_data = '0;
    if (!access)
      fwd_data = DATA_W'(ex_out);
    else if (!mis && is_ld)
      fwd_data = is_spm ? spm_rd_data : (rd_valid ? rd_buf : bus_rd_data);
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      mem_en         <= 1'b0;
      mem_out        <= '0;
      mem_miss_align <= 1'b0;
    end else if (!(stall || busy)) begin
      mem_en         <= ex_en;
      mem_out        <= fwd_data;
      mem_miss_align <= mis;
    end
  end

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Directed self-checking bench for mem_stage_wbuf: SPM, posted stores, ordered bus loads,
// misalignment, flush during a bus read and reset mid-transaction.
module tb_mem_stage_wbuf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;

  logic clk = 1'b0;
  logic reset, stall, flush, busy, ex_en;
  logic [1:0] ex_mem_op;
  logic [ADDR_W+1:0] ex_out;
  logic [DATA_W-1:0] ex_mem_wr_data, spm_wr_data, spm_rd_data;
  logic [ADDR_W-1:0] spm_addr, bus_addr;
  logic spm_as_, spm_rw, bus_req_, bus_as_, bus_rw, bus_grnt_, bus_rdy_;
  logic [DATA_W-1:0] bus_wr_data, bus_rd_data, fwd_data, mem_out;
  logic mem_en, mem_miss_align, wbuf_empty;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] log_q [16];
  int log_n = 0;

  mem_stage_wbuf dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_out(ex_out), .ex_mem_wr_data(ex_mem_wr_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data), .bus_req_(bus_req_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_grnt_(bus_grnt_), .bus_rdy_(bus_rdy_),
    .bus_rd_data(bus_rd_data), .fwd_data(fwd_data), .mem_en(mem_en),
    .mem_miss_align(mem_miss_align), .mem_out(mem_out), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  // Record every bus address strobe in issue order
  always @(negedge clk) begin
    if (reset === 1'b1 && bus_as_ === 1'b0) begin
      if (log_n < 16) log_q[log_n] = {1'b0, bus_rw, bus_addr, bus_wr_data};
      log_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    ex_en = en;
    ex_mem_op = op;
    ex_out = a;
    ex_mem_wr_data = d;
  endtask

  task automatic wait_as();
    int n;
    n = 0;
    while (bus_as_ !== 1'b0 && n < 64) begin
      cyc();
      n++;
    end
    chk("bus_as_seen", 64'(bus_as_), 64'd0);
  endtask

  // Complete one bus transaction with wc wait cycles
  task automatic do_bus(input int wc);
    wait_as();
    cyc();
    repeat (wc) cyc();
    bus_rdy_ = 1'b0;
    cyc();
    bus_rdy_ = 1'b1;
  endtask

  function automatic logic [63:0] ent(input logic rw, input logic [29:0] a, input logic [31:0] d);
    return {1'b0, rw, a, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; spm_rd_data = '0; bus_rd_data = '0;
    cyc(); cyc();

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bus_req", 64'(bus_req_), 64'd1);
    chk("rst_bus_as", 64'(bus_as_), 64'd1);
    chk("rst_spm_as", 64'(spm_as_), 64'd1);
    chk("rst_bus_rw", 64'(bus_rw), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(bus_wr_data), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_out", 64'(mem_out), 64'd0);
    chk("rst_miss", 64'(mem_miss_align), 64'd0);
    chk("rst_wbuf_empty", 64'(wbuf_empty), 64'd1);
    reset = 1'b1;
    cyc();

    // SPM load
    drive(1'b1, 2'b01, 32'h6000_0010, 32'h0);
    spm_rd_data = 32'hDEAD_BEEF;
    settle();
    chk("spm_ld_as", 64'(spm_as_), 64'd0);
    chk("spm_ld_addr", 64'(spm_addr), 64'h1800_0004);
    chk("spm_ld_rw", 64'(spm_rw), 64'd0);
    chk("spm_ld_busy", 64'(busy), 64'd0);
    chk("spm_ld_fwd", 64'(fwd_data), 64'hDEAD_BEEF);
    cyc();
    chk("spm_ld_mem_out", 64'(mem_out), 64'hDEAD_BEEF);
    chk("spm_ld_mem_en", 64'(mem_en), 64'd1);

    // SPM store
    drive(1'b1, 2'b10, 32'h6000_0020, 32'h0BAD_CAFE);
    settle();
    chk("spm_st_as", 64'(spm_as_), 64'd0);
    chk("spm_st_rw", 64'(spm_rw), 64'd1);
    chk("spm_st_wdata", 64'(spm_wr_data), 64'h0BAD_CAFE);
    chk("spm_st_busy", 64'(busy), 64'd0);
    cyc();
    chk("spm_st_wbuf_empty", 64'(wbuf_empty), 64'd1);
    chk("spm_st_no_req", 64'(bus_req_), 64'd1);

    // Non-memory and reserved ops pass ex_out through
    drive(1'b1, 2'b00, 32'h1234_5678, 32'h0);
    settle();
    chk("alu_fwd", 64'(fwd_data), 64'h1234_5678);
    cyc();
    chk("alu_mem_out", 64'(mem_out), 64'h1234_5678);
    drive(1'b1, 2'b11, 32'h0000_0103, 32'h0);
    settle();
    chk("rsvd_fwd", 64'(fwd_data), 64'h0000_0103);
    chk("rsvd_spm_as", 64'(spm_as_), 64'd1);
    cyc();

    // Misaligned load
    drive(1'b1, 2'b01, 32'h0000_0102, 32'h0);
    settle();
    chk("mis_spm_as", 64'(spm_as_), 64'd1);
    chk("mis_busy", 64'(busy), 64'd0);
    chk("mis_fwd", 64'(fwd_data), 64'd0);
    cyc();
    chk("mis_flag", 64'(mem_miss_align), 64'd1);
    chk("mis_mem_out", 64'(mem_out), 64'd0);
    chk("mis_mem_en", 64'(mem_en), 64'd1);
    chk("mis_no_req", 64'(bus_req_), 64'd1);
    chk("mis_no_as", 64'(bus_as_), 64'd1);
    drive(1'b1, 2'b10, 32'h6000_0001, 32'h1);
    settle();
    chk("mis_st_spm_as", 64'(spm_as_), 64'd1);
    cyc();
    chk("mis_st_wbuf_empty", 64'(wbuf_empty), 64'd1);

    // Five bus stores, grant withheld
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      settle();
      chk("st_no_busy", 64'(busy), 64'd0);
      cyc();
    end
    chk("st_wbuf_not_empty", 64'(wbuf_empty), 64'd0);
    drive(1'b1, 2'b10, 32'h210, 32'hA000_0004);
    bus_grnt_ = 1'b0;
    settle();
    chk("st5_busy", 64'(busy), 64'd1);
    cyc();
    chk("st5_busy_access", 64'(busy), 64'd1);
    chk("st0_as", 64'(bus_as_), 64'd0);
    chk("st0_addr", 64'(bus_addr), 64'h80);
    chk("st0_rw", 64'(bus_rw), 64'd1);
    chk("st0_wdata", 64'(bus_wr_data), 64'hA000_0000);
    cyc();
    chk("st0_as_one_cycle", 64'(bus_as_), 64'd1);
    chk("st5_busy_wait", 64'(busy), 64'd1);
    bus_rdy_ = 1'b0;
    settle();
    chk("st5_busy_rdy", 64'(busy), 64'd1);
    cyc();
    bus_rdy_ = 1'b1;
    chk("st5_busy_clear", 64'(busy), 64'd0);
    cyc();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) do_bus(0);
    chk("st_drained_empty", 64'(wbuf_empty), 64'd1);

    // Store then load same address: write must finish before the read strobe
    drive(1'b1, 2'b10, 32'h100, 32'h1111_2222);
    settle();
    chk("sl_st_busy", 64'(busy), 64'd0);
    cyc();
    drive(1'b1, 2'b01, 32'h100, 32'h0);
    settle();
    chk("sl_ld_busy", 64'(busy), 64'd1);
    chk("sl_wbuf_empty", 64'(wbuf_empty), 64'd0);
    wait_as();
    chk("sl_wr_rw", 64'(bus_rw), 64'd1);
    cyc();
    cyc(); cyc();
    chk("sl_busy_in_wait", 64'(busy), 64'd1);
    bus_rdy_ = 1'b0;
    cyc();
    bus_rdy_ = 1'b1;
    wait_as();
    chk("sl_rd_rw", 64'(bus_rw), 64'd0);
    chk("sl_rd_addr", 64'(bus_addr), 64'h40);
    cyc();
    cyc(); cyc();
    chk("sl_rd_busy", 64'(busy), 64'd1);
    bus_rdy_ = 1'b0;
    bus_rd_data = 32'hCAFE_F00D;
    settle();
    chk("sl_rd_busy_rdy", 64'(busy), 64'd0);
    chk("sl_rd_fwd", 64'(fwd_data), 64'hCAFE_F00D);
    cyc();
    bus_rdy_ = 1'b1;
    chk("sl_mem_out", 64'(mem_out), 64'hCAFE_F00D);
    chk("sl_mem_en", 64'(mem_en), 64'd1);
    drive(1'b0, 2'b00, 32'h0, 32'h0);

    // Flush while a bus load sits in WAIT
    drive(1'b1, 2'b00, 32'h55, 32'h0);
    cyc();
    drive(1'b1, 2'b01, 32'h300, 32'h0);
    wait_as();
    chk("fl_rd_rw", 64'(bus_rw), 64'd0);
    chk("fl_rd_addr", 64'(bus_addr), 64'hC0);
    cyc();
    chk("fl_mem_en_before", 64'(mem_en), 64'd1);
    chk("fl_mem_out_held", 64'(mem_out), 64'h55);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    chk("fl_mem_en_after", 64'(mem_en), 64'd0);
    chk("fl_bus_still_req", 64'(bus_req_), 64'd0);
    bus_rdy_ = 1'b0;
    bus_rd_data = 32'h9999_9999;
    settle();
    chk("fl_busy", 64'(busy), 64'd0);
    cyc();
    bus_rdy_ = 1'b1;
    chk("fl_idle_req", 64'(bus_req_), 64'd1);
    chk("fl_mem_out_discard", 64'(mem_out), 64'd0);
    cyc();
    chk("fl_no_retry", 64'(bus_req_), 64'd1);
    chk("fl_mem_en_stays", 64'(mem_en), 64'd0);

    // Reset with two stores buffered, first one in WAIT
    bus_grnt_ = 1'b1;
    drive(1'b1, 2'b10, 32'h400, 32'h4444_0000);
    cyc();
    drive(1'b1, 2'b10, 32'h404, 32'h4444_0001);
    cyc();
    drive(1'b1, 2'b00, 32'h77, 32'h0);
    bus_grnt_ = 1'b0;
    wait_as();
    chk("rw_wr_addr", 64'(bus_addr), 64'h100);
    cyc();
    chk("rw_pre_wbuf", 64'(wbuf_empty), 64'd0);
    chk("rw_pre_mem_en", 64'(mem_en), 64'd1);
    chk("rw_pre_req", 64'(bus_req_), 64'd0);
    reset = 1'b0;
    cyc();
    chk("rw_req", 64'(bus_req_), 64'd1);
    chk("rw_wbuf_empty", 64'(wbuf_empty), 64'd1);
    chk("rw_mem_en", 64'(mem_en), 64'd0);
    chk("rw_as", 64'(bus_as_), 64'd1);
    chk("rw_bus_rw", 64'(bus_rw), 64'd0);
    reset = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    cyc(); cyc();
    chk("rw_stays_idle", 64'(bus_req_), 64'd1);
    chk("rw_stays_empty", 64'(wbuf_empty), 64'd1);

    // Bus strobe order across the whole run
    chk("log_count", 64'(log_n), 64'd9);
    for (int i = 0; i < 5; i++)
      chk("log_st_order", log_q[i], ent(1'b1, 30'h80 + 30'(i), 32'hA000_0000 + 32'(i)));
    chk("log_sl_wr", log_q[5], ent(1'b1, 30'h40, 32'h1111_2222));
    chk("log_sl_rd", log_q[6], ent(1'b0, 30'h40, 32'h0));
    chk("log_fl_rd", log_q[7], ent(1'b0, 30'hC0, 32'h0));
    chk("log_rw_wr", log_q[8], ent(1'b1, 30'h100, 32'h4444_0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
